// File: rtl/dmi_host_bridge.sv
// Parallel-bus DMI initiator with DTM semantics: one outstanding transaction,
// sticky dmistat, abortable hard reset and a response timeout.
module dmi_host_bridge #(
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth      = (TimeoutCycles > 32'd0) ? $clog2(TimeoutCycles + 32'd1) : 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_req_i,
  input  logic [1:0]  host_op_i,
  input  logic [6:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_rvalid_o,
  output logic [31:0] host_rdata_o,
  output logic [1:0]  host_status_o,
  output logic [1:0]  dmistat_o,
  output logic        busy_o,
  input  logic        dmireset_i,
  input  logic        dmihardreset_i,
  output logic [40:0] dmi_req_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  input  logic [33:0] dmi_resp_i,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o
);

  localparam logic [1:0] OpNop     = 2'h0;
  localparam logic [1:0] StSuccess = 2'h0;
  localparam logic [1:0] StErr     = 2'h2;
  localparam logic [1:0] StBusy    = 2'h3;
  localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    Req      = 2'd1,
    WaitResp = 2'd2,
    Drain    = 2'd3
  } state_e;

  state_e              state_r, state_s;
  logic [CntWidth-1:0] cnt_r, cnt_s;
  logic [40:0]         req_r, req_s;
  logic                rvalid_r, rvalid_s;
  logic [31:0]         rdata_r, rdata_s;
  logic [1:0]          status_r, status_s;
  logic [1:0]          dmistat_r, dmistat_s;
  logic [1:0]          stat_base_s;
  logic                err_evt_s, busy_evt_s;
  logic                req_valid_r, resp_ready_r, busy_r;

  // Next-state, completion and sticky-status decisions
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    req_s      = req_r;
    rvalid_s   = 1'b0;
    rdata_s    = rdata_r;
    status_s   = status_r;
    err_evt_s  = 1'b0;
    busy_evt_s = 1'b0;

    if (dmihardreset_i) begin
      case (state_r)
        Req:      state_s = Idle;
        // a response handshaking in the abort cycle is already consumed
        WaitResp: state_s = dmi_resp_valid_i ? Idle : Drain;
        default:  state_s = state_r;
      endcase
    end else begin
      case (state_r)
        Idle: begin
          if (host_req_i) begin
            if (dmistat_r != StSuccess) begin
              rvalid_s = 1'b1;
              status_s = dmistat_r;
            end else if (host_op_i == OpNop) begin
              rvalid_s = 1'b1;
              status_s = StSuccess;
            end else begin
              req_s   = {host_addr_i, host_op_i, host_wdata_i};
              state_s = Req;
            end
          end else begin
            state_s = Idle;
          end
        end
        Req: begin
          if (dmi_req_ready_i) begin
            state_s = WaitResp;
            cnt_s   = '0;
          end else begin
            state_s = Req;
          end
        end
        WaitResp: begin
          if (dmi_resp_valid_i) begin
            rvalid_s = 1'b1;
            rdata_s  = dmi_resp_i[33:2];
            state_s  = Idle;
            if (dmi_resp_i[1:0] == 2'b00) begin
              status_s = StSuccess;
            end else begin
              status_s  = StErr;
              err_evt_s = 1'b1;
            end
          end else if (TimeoutCycles != 32'd0) begin
            cnt_s = cnt_r + CntOne;
            if ((cnt_r + CntOne) == TimeoutVal) begin
              rvalid_s  = 1'b1;
              status_s  = StErr;
              err_evt_s = 1'b1;
              state_s   = Drain;
            end else begin
              state_s = WaitResp;
            end
          end else begin
            state_s = WaitResp;
          end
        end
        Drain: begin
          if (dmi_resp_valid_i) begin
            state_s = Idle;
          end else begin
            state_s = Drain;
          end
        end
        default: state_s = Idle;
      endcase
      busy_evt_s = host_req_i && (state_r != Idle);
    end

    // a fresh error in the same cycle as dmireset survives the clear
    stat_base_s = dmireset_i ? StSuccess : dmistat_r;
    if (dmihardreset_i) begin
      dmistat_s = StSuccess;
    end else if ((stat_base_s == StSuccess) && err_evt_s) begin
      dmistat_s = StErr;
    end else if ((stat_base_s == StSuccess) && busy_evt_s) begin
      dmistat_s = StBusy;
    end else begin
      dmistat_s = stat_base_s;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= Idle;
      cnt_r        <= '0;
      req_r        <= 41'd0;
      rvalid_r     <= 1'b0;
      rdata_r      <= 32'd0;
      status_r     <= StSuccess;
      dmistat_r    <= StSuccess;
      req_valid_r  <= 1'b0;
      resp_ready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      req_r        <= req_s;
      rvalid_r     <= rvalid_s;
      rdata_r      <= rdata_s;
      status_r     <= status_s;
      dmistat_r    <= dmistat_s;
      req_valid_r  <= (state_s == Req);
      resp_ready_r <= (state_s == WaitResp) || (state_s == Drain);
      busy_r       <= (state_s != Idle);
    end
  end

  assign host_rvalid_o    = rvalid_r;
  assign host_rdata_o     = rdata_r;
  assign host_status_o    = status_r;
  assign dmistat_o        = dmistat_r;
  assign busy_o           = busy_r;
  assign dmi_req_o        = req_r;
  assign dmi_req_valid_o  = req_valid_r;
  assign dmi_resp_ready_o = resp_ready_r;

endmodule
